// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side control bus between the pipeline datapath and the hazard controller.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [31:0]      ins_id;
  logic             id_valid;
  logic             ex_branch_taken;
  logic             wb_we;
  logic [4:0]       wb_addr;
  logic             stall_if;
  logic             bubble_id;
  logic             flush_if;
  logic             halt_f;
  logic             halted;
  logic [31:0]      busy;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output ins_id, id_valid, ex_branch_taken, wb_we, wb_addr,
    input  stall_if, bubble_id, flush_if, halt_f, halted, busy, stall_cnt, flush_cnt
  );

  modport slave (
    input  ins_id, id_valid, ex_branch_taken, wb_we, wb_addr,
    output stall_if, bubble_id, flush_if, halt_f, halted, busy, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: register scoreboard, stall/bubble/flush
// generation for the instruction in IF/ID, and HLT drain-then-freeze sequencing.
module pipe_hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int unsigned DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  localparam logic [5:0] OP_LW    = 6'b000001;
  localparam logic [5:0] OP_SW    = 6'b000010;
  localparam logic [5:0] OP_ADD   = 6'b000011;
  localparam logic [5:0] OP_SUB   = 6'b000100;
  localparam logic [5:0] OP_AND   = 6'b000101;
  localparam logic [5:0] OP_OR    = 6'b000110;
  localparam logic [5:0] OP_MUL   = 6'b000111;
  localparam logic [5:0] OP_SLT   = 6'b001000;
  localparam logic [5:0] OP_ADDI  = 6'b001001;
  localparam logic [5:0] OP_SUBI  = 6'b001010;
  localparam logic [5:0] OP_SLTI  = 6'b001011;
  localparam logic [5:0] OP_BEQZ  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [DW-1:0]    drain_cnt, drain_next;
  logic [31:0]      busy, busy_next;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  logic [5:0] opcode;
  logic [4:0] rs, rt, rd;
  logic [4:0] dest;
  logic       use_rs, use_rt, is_hlt;
  logic       hazard_c, stall_c, bubble_c, flush_c, halt_c, issue_c;
  logic       unused_bits;

  assign opcode      = bus.ins_id[31:26];
  assign rs          = bus.ins_id[25:21];
  assign rt          = bus.ins_id[20:16];
  assign rd          = bus.ins_id[15:11];
  assign unused_bits = ^bus.ins_id[10:0];

  // Operand usage and destination per opcode class; unknown opcodes act as HLT.
  always_comb begin
    use_rs = 1'b0;
    use_rt = 1'b0;
    dest   = 5'd0;
    is_hlt = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_SLT: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
        dest   = rd;
      end
      OP_ADDI, OP_SUBI, OP_SLTI, OP_LW: begin
        use_rs = 1'b1;
        dest   = rt;
      end
      OP_SW: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      OP_BEQZ, OP_BNEQZ: begin
        use_rs = 1'b1;
      end
      default: begin
        is_hlt = 1'b1;
      end
    endcase
  end

  // RAW hazard against the registered scoreboard only (no WB bypass).
  assign hazard_c = bus.id_valid &
                    ((use_rs & (rs != 5'd0) & busy[rs]) |
                     (use_rt & (rt != 5'd0) & busy[rt]));

  // Next-state and per-cycle control priority: flush, hazard, issue.
  always_comb begin
    state_next = state;
    drain_next = drain_cnt;
    stall_c    = 1'b0;
    bubble_c   = 1'b0;
    flush_c    = 1'b0;
    halt_c     = 1'b0;
    issue_c    = 1'b0;
    case (state)
      RUN: begin
        if (bus.ex_branch_taken) begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
        end else if (hazard_c) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
        end else if (bus.id_valid) begin
          issue_c = 1'b1;
          if (is_hlt) begin
            state_next = DRAIN;
            drain_next = DW'(DRAIN_CYCLES);
          end
        end
      end
      DRAIN: begin
        stall_c  = 1'b1;
        bubble_c = 1'b1;
        if (drain_cnt <= DW'(1)) begin
          state_next = HALTED;
          drain_next = DW'(0);
        end else begin
          drain_next = drain_cnt - DW'(1);
        end
      end
      HALTED: begin
        stall_c  = 1'b1;
        bubble_c = 1'b1;
        halt_c   = 1'b1;
      end
      default: begin
        state_next = RUN;
        drain_next = DW'(0);
      end
    endcase
  end

  // Scoreboard update: WB clear first so a same-cycle issue set wins.
  always_comb begin
    busy_next = busy;
    if (bus.wb_we && (bus.wb_addr != 5'd0)) begin
      busy_next[bus.wb_addr] = 1'b0;
    end
    if (issue_c && (dest != 5'd0)) begin
      busy_next[dest] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // FSM state and drain counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      drain_cnt <= DW'(0);
    end else begin
      state     <= state_next;
      drain_cnt <= drain_next;
    end
  end

  // Register scoreboard.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 32'd0;
    end else begin
      busy <= busy_next;
    end
  end

  // Saturating performance counters for RUN hazard stalls and taken flushes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= CNT_W'(0);
      flush_cnt <= CNT_W'(0);
    end else begin
      if ((state == RUN) && stall_c && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush_c && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

  // Controls are forced low while reset is held, whatever the inputs do.
  assign bus.stall_if  = rst & stall_c;
  assign bus.bubble_id = rst & bubble_c;
  assign bus.flush_if  = rst & flush_c;
  assign bus.halt_f    = rst & halt_c;
  assign bus.halted    = rst & halt_c;
  assign bus.busy      = busy;
  assign bus.stall_cnt = stall_cnt;
  assign bus.flush_cnt = flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus a
// randomized run against a behavioural scoreboard/sequence model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned DRAIN = 3;
  localparam int unsigned CNT_W = 16;

  localparam logic [5:0] OP_LW   = 6'd1;
  localparam logic [5:0] OP_ADD  = 6'd3;
  localparam logic [5:0] OP_ADDI = 6'd9;
  localparam logic [31:0] INS_HLT = 32'hFC00_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model state.
  bit [31:0] m_busy;
  int        m_drain;
  bit        m_halted;
  int        m_stalls;
  int        m_flushes;

  function automatic logic [31:0] enc_r(input logic [5:0] op, input int rd, input int rs, input int rt);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [4:0] ctl();
    return {bus.stall_if, bus.bubble_id, bus.flush_if, bus.halt_f, bus.halted};
  endfunction

  task automatic drive(input logic [31:0] ins, input logic v, input logic tk, input logic we, input logic [4:0] a);
    bus.ins_id          = ins;
    bus.id_valid        = v;
    bus.ex_branch_taken = tk;
    bus.wb_we           = we;
    bus.wb_addr         = a;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    drive(32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Sources (-1 = none), destination (-1 = none) and halt flag from the ISA table.
  function automatic void m_decode(input logic [31:0] ins, output int s0, output int s1, output int d, output bit hlt);
    int op;
    op  = int'(ins[31:26]);
    s0  = -1;
    s1  = -1;
    d   = -1;
    hlt = 1'b0;
    if (op >= 3 && op <= 8) begin
      s0 = int'(ins[25:21]); s1 = int'(ins[20:16]); d = int'(ins[15:11]);
    end else if (op == 1 || (op >= 9 && op <= 11)) begin
      s0 = int'(ins[25:21]); d = int'(ins[20:16]);
    end else if (op == 2) begin
      s0 = int'(ins[25:21]); s1 = int'(ins[20:16]);
    end else if (op == 12 || op == 13) begin
      s0 = int'(ins[25:21]);
    end else begin
      hlt = 1'b1;
    end
  endfunction

  function automatic bit m_hazard();
    int s0, s1, d;
    bit hlt;
    m_decode(bus.ins_id, s0, s1, d, hlt);
    return bus.id_valid && ((s0 > 0 && m_busy[s0]) || (s1 > 0 && m_busy[s1]));
  endfunction

  function automatic logic [4:0] m_expect();
    if (m_halted)                 return 5'b11011;
    if (m_drain > 0)              return 5'b11000;
    if (bus.ex_branch_taken)      return 5'b01100;
    if (m_hazard())               return 5'b11000;
    return 5'b00000;
  endfunction

  task automatic m_clear();
    m_busy = '0; m_drain = 0; m_halted = 1'b0; m_stalls = 0; m_flushes = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic m_step();
    int s0, s1, d;
    bit hlt, running;
    int set_reg;
    m_decode(bus.ins_id, s0, s1, d, hlt);
    running = !m_halted && m_drain == 0;
    set_reg = 0;
    if (running) begin
      if (bus.ex_branch_taken) m_flushes = (m_flushes < 65535) ? m_flushes + 1 : m_flushes;
      else if (m_hazard()) m_stalls = (m_stalls < 65535) ? m_stalls + 1 : m_stalls;
      else if (bus.id_valid) begin
        if (d > 0) set_reg = d;
        if (hlt) m_drain = DRAIN;
      end
    end else if (!m_halted) begin
      m_drain = m_drain - 1;
      if (m_drain == 0) m_halted = 1'b1;
    end
    if (bus.wb_we && bus.wb_addr != 5'd0) m_busy[bus.wb_addr] = 1'b0;
    if (set_reg > 0) m_busy[set_reg] = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(enc_r(OP_ADD, 3, 1, 2), 1'b1, 1'b1, 1'b0, 5'd0);
    #3;
    n_cmp++; if (ctl() !== 5'b0) begin n_fail++; $display("FAIL rst_ctl: got %b expected 00000", ctl()); end
    n_cmp++; if (bus.busy !== 32'd0) begin n_fail++; $display("FAIL rst_busy: got %h expected 0", bus.busy); end
    n_cmp++; if ({bus.stall_cnt, bus.flush_cnt} !== 32'd0) begin n_fail++; $display("FAIL rst_cnt: got %h expected 0", {bus.stall_cnt, bus.flush_cnt}); end
    apply_reset();
    drive(enc_r(OP_ADD, 3, 1, 2), 1'b1, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    n_cmp++; if (ctl() !== 5'b0) begin n_fail++; $display("FAIL rst_first_issue: got %b expected 00000", ctl()); end
    cyc();
  endtask

  task automatic test_load_use();
    int stalls, issue_at;
    apply_reset();
    drive(enc_i(OP_LW, 2, 1, 0), 1'b1, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    n_cmp++; if (ctl() !== 5'b0) begin n_fail++; $display("FAIL lu_lw_issue: got %b expected 00000", ctl()); end
    cyc();
    drive(enc_r(OP_ADD, 3, 2, 4), 1'b1, 1'b0, 1'b0, 5'd2);
    stalls = 0;
    issue_at = -1;
    for (int k = 0; k < 8; k++) begin
      bus.wb_we = (k == 2);
      @(negedge clk);
      if (bus.stall_if === 1'b1 && bus.bubble_id === 1'b1) stalls++;
      else if (issue_at < 0) issue_at = k;
      cyc();
      if (issue_at >= 0) break;
    end
    drive(32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    n_cmp++; if (stalls !== 3) begin n_fail++; $display("FAIL lu_stall_cycles: got %0d expected 3", stalls); end
    n_cmp++; if (issue_at !== 3) begin n_fail++; $display("FAIL lu_issue_cycle: got %0d expected 3", issue_at); end
    n_cmp++; if (bus.stall_cnt !== 16'd3) begin n_fail++; $display("FAIL lu_stall_cnt: got %0d expected 3", bus.stall_cnt); end
    n_cmp++; if (bus.busy !== 32'h0000_0008) begin n_fail++; $display("FAIL lu_busy: got %h expected 00000008", bus.busy); end
  endtask

  task automatic test_r0_dest();
    apply_reset();
    drive(enc_i(OP_ADDI, 0, 1, 5), 1'b1, 1'b0, 1'b0, 5'd0);
    cyc();
    n_cmp++; if (bus.busy !== 32'd0) begin n_fail++; $display("FAIL r0_busy: got %h expected 0", bus.busy); end
    drive(enc_r(OP_ADD, 3, 0, 0), 1'b1, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    n_cmp++; if (bus.stall_if !== 1'b0) begin n_fail++; $display("FAIL r0_stall: got %b expected 0", bus.stall_if); end
    cyc();
    drive(32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    n_cmp++; if (bus.stall_cnt !== 16'd0) begin n_fail++; $display("FAIL r0_stall_cnt: got %0d expected 0", bus.stall_cnt); end
  endtask

  task automatic test_flush_beats_hazard();
    apply_reset();
    drive(enc_i(OP_LW, 2, 1, 0), 1'b1, 1'b0, 1'b0, 5'd0);
    cyc();
    drive(enc_r(OP_ADD, 3, 2, 4), 1'b1, 1'b1, 1'b0, 5'd0);
    @(negedge clk);
    n_cmp++; if (ctl() !== 5'b01100) begin n_fail++; $display("FAIL fl_ctl: got %b expected 01100", ctl()); end
    cyc();
    drive(32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    n_cmp++; if (bus.busy !== 32'h0000_0004) begin n_fail++; $display("FAIL fl_busy: got %h expected 00000004", bus.busy); end
    n_cmp++; if (bus.flush_cnt !== 16'd1) begin n_fail++; $display("FAIL fl_flush_cnt: got %0d expected 1", bus.flush_cnt); end
    n_cmp++; if (bus.stall_cnt !== 16'd0) begin n_fail++; $display("FAIL fl_stall_cnt: got %0d expected 0", bus.stall_cnt); end
    cyc();
  endtask

  task automatic test_hlt_sequence();
    apply_reset();
    drive(enc_i(OP_LW, 7, 0, 0), 1'b1, 1'b0, 1'b0, 5'd0);
    cyc();
    drive(INS_HLT, 1'b1, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    n_cmp++; if (ctl() !== 5'b0) begin n_fail++; $display("FAIL hlt_issue: got %b expected 00000", ctl()); end
    cyc();
    drive(INS_HLT, 1'b1, 1'b0, 1'b1, 5'd7);
    @(negedge clk);
    n_cmp++; if (ctl() !== 5'b11000) begin n_fail++; $display("FAIL hlt_drain1: got %b expected 11000", ctl()); end
    cyc();
    drive(INS_HLT, 1'b1, 1'b1, 1'b0, 5'd0);
    @(negedge clk);
    n_cmp++; if (ctl() !== 5'b11000) begin n_fail++; $display("FAIL hlt_drain2: got %b expected 11000", ctl()); end
    n_cmp++; if (bus.busy[7] !== 1'b0) begin n_fail++; $display("FAIL hlt_wb_clear: got %b expected 0", bus.busy[7]); end
    cyc();
    drive(INS_HLT, 1'b1, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    n_cmp++; if (ctl() !== 5'b11000) begin n_fail++; $display("FAIL hlt_drain3: got %b expected 11000", ctl()); end
    cyc();
    @(negedge clk);
    n_cmp++; if (ctl() !== 5'b11011) begin n_fail++; $display("FAIL hlt_halted: got %b expected 11011", ctl()); end
    cyc();
    @(negedge clk);
    n_cmp++; if (ctl() !== 5'b11011) begin n_fail++; $display("FAIL hlt_sticky: got %b expected 11011", ctl()); end
    n_cmp++; if (bus.flush_cnt !== 16'd0) begin n_fail++; $display("FAIL hlt_flush_cnt: got %0d expected 0", bus.flush_cnt); end
    cyc();
  endtask

  task automatic test_set_beats_clear();
    apply_reset();
    drive(enc_i(OP_LW, 5, 1, 0), 1'b1, 1'b0, 1'b1, 5'd5);
    cyc();
    drive(32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    n_cmp++; if (bus.busy !== 32'h0000_0020) begin n_fail++; $display("FAIL sbc_busy: got %h expected 00000020", bus.busy); end
    cyc();
  endtask

  task automatic test_async_reset_drain();
    apply_reset();
    drive(enc_i(OP_LW, 9, 1, 0), 1'b1, 1'b0, 1'b0, 5'd0);
    cyc();
    drive(32'd0, 1'b0, 1'b1, 1'b0, 5'd0);
    cyc();
    drive(INS_HLT, 1'b1, 1'b0, 1'b0, 5'd0);
    cyc();
    drive(INS_HLT, 1'b1, 1'b1, 1'b0, 5'd0);
    #1;
    n_cmp++; if (ctl() !== 5'b11000) begin n_fail++; $display("FAIL ar_in_drain: got %b expected 11000", ctl()); end
    n_cmp++; if (bus.flush_cnt !== 16'd1) begin n_fail++; $display("FAIL ar_pre_flush_cnt: got %0d expected 1", bus.flush_cnt); end
    #1;
    rst = 1'b0;
    #1;
    n_cmp++; if (ctl() !== 5'b0) begin n_fail++; $display("FAIL ar_ctl: got %b expected 00000", ctl()); end
    n_cmp++; if (bus.busy !== 32'd0) begin n_fail++; $display("FAIL ar_busy: got %h expected 0", bus.busy); end
    n_cmp++; if ({bus.stall_cnt, bus.flush_cnt} !== 32'd0) begin n_fail++; $display("FAIL ar_cnt: got %h expected 0", {bus.stall_cnt, bus.flush_cnt}); end
    cyc();
    rst = 1'b1;
    drive(enc_r(OP_ADD, 3, 1, 4), 1'b1, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    n_cmp++; if (ctl() !== 5'b0) begin n_fail++; $display("FAIL ar_post_issue: got %b expected 00000", ctl()); end
    cyc();
    drive(32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    n_cmp++; if (bus.busy !== 32'h0000_0008) begin n_fail++; $display("FAIL ar_post_busy: got %h expected 00000008", bus.busy); end
  endtask

  task automatic test_random();
    int halted_for;
    logic [5:0] op;
    logic [4:0] e;
    apply_reset();
    m_clear();
    halted_for = 0;
    for (int i = 0; i < 1500; i++) begin
      if (m_halted && halted_for >= 4) begin
        apply_reset();
        m_clear();
        halted_for = 0;
      end
      if ($urandom % 100 < 2) op = ($urandom % 2 == 0) ? 6'h3F : 6'(14 + $urandom % 49);
      else op = 6'(1 + $urandom % 13);
      drive({op, 5'($urandom % 8), 5'($urandom % 8), 5'($urandom % 8), 11'($urandom)},
            1'($urandom % 10 < 8), 1'($urandom % 10 == 0), 1'($urandom % 10 < 3), 5'($urandom % 8));
      @(negedge clk);
      e = m_expect();
      n_cmp++; if (ctl() !== e) begin n_fail++; $display("FAIL rnd_ctl[%0d]: got %b expected %b", i, ctl(), e); end
      n_cmp++; if (bus.busy !== m_busy) begin n_fail++; $display("FAIL rnd_busy[%0d]: got %h expected %h", i, bus.busy, m_busy); end
      n_cmp++; if ({bus.stall_cnt, bus.flush_cnt} !== {16'(m_stalls), 16'(m_flushes)}) begin
        n_fail++; $display("FAIL rnd_cnt[%0d]: got %h expected %h", i, {bus.stall_cnt, bus.flush_cnt}, {16'(m_stalls), 16'(m_flushes)});
      end
      m_step();
      if (m_halted) halted_for++;
      cyc();
    end
    drive(32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    drive(32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    test_reset();
    test_load_use();
    test_r0_dest();
    test_flush_beats_hazard();
    test_hlt_sequence();
    test_set_beats_clear();
    test_async_reset_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage MIPS32 core. It sits beside the decode stage and inspects the instruction currently in IF/ID. It keeps a register scoreboard and generates the fetch stall, ID/EX bubble and IF/ID flush controls. It also sequences HLT through a drain phase into the frozen state that drives halt_f to all stages.

Parameters:
DRAIN_CYCLES, 3, cycles after HLT issue before the pipeline counts as empty (EX, MEM, WB)
CNT_W, 16, width of the stall and flush performance counters

Ports:
clk  input  1  pipeline clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset; one clock domain
ins_id  input  32  instruction in IF/ID (being decoded this cycle)
id_valid  input  1  ins_id holds a real instruction (0 = bubble)
ex_branch_taken  input  1  branch in EX resolved taken this cycle
wb_we  input  1  register-file write in WB this cycle
wb_addr  input  5  WB destination register
stall_if  output  1  hold PC and IF/ID
bubble_id  output  1  load NOP into ID/EX instead of ins_id
flush_if  output  1  squash instruction being fetched (IF/ID <= NOP)
halt_f  output  1  freeze all stages
halted  output  1  core halted, sticky until reset
busy  output  32  scoreboard, bit n = write to Rn pending; bit 0 always 0
stall_cnt  output  CNT_W  count of hazard-stall cycles, saturating
flush_cnt  output  CNT_W  count of taken-branch flushes, saturating

Behaviour:
- Opcode field is ins_id[31:26]:
  LW=000001, SW=000010, ADD=000011, SUB=000100, AND=000101, OR=000110, MUL=000111, SLT=001000, ADDI=001001, SUBI=001010, SLTI=001011, BEQZ=001100, BNEQZ=001101, HLT=111111.
  Any other opcode is treated as HLT.
- Sources:
  - rr_alu: rs [25:21] and rt [20:16].
  - ri_alu, LW, branches: rs only.
  - SW: rs and rt.
  - HLT: none.
- Destination:
  - rr_alu: rd [15:11].
  - ri_alu and LW: rt [20:16].
  - Others: none.
  - A destination of R0 is never tracked.
- hazard = id_valid and any source n != 0 with busy[n] = 1. Only the registered busy is used: a WB write becomes visible to ID the cycle after wb_we.
- Priority each cycle (combinational outputs), checked in order:
  1. Taken flush: ex_branch_taken = 1 in RUN gives flush_if = 1, bubble_id = 1, stall_if = 0. ins_id is discarded. No scoreboard set.
  2. Hazard: gives stall_if = 1, bubble_id = 1, flush_if = 0.
  3. Otherwise, with id_valid = 1, ins_id issues: all controls 0.
- Scoreboard:
  - On issue with a destination d != 0, busy[d] <= 1.
  - wb_we with wb_addr != 0 clears busy[wb_addr].
  - Set and clear of the same bit in the same cycle: set wins.
  - Clears are applied in every state.
- FSM states: RUN, DRAIN, HALTED.
  - RUN -> DRAIN when HLT (or an illegal opcode) issues. The drain counter loads DRAIN_CYCLES.
  - DRAIN: stall_if = 1, bubble_id = 1, flush_if = 0. The counter decrements each cycle. At 1 -> HALTED. ex_branch_taken is ignored.
  - HALTED: halt_f = 1, halted = 1, stall_if = 1, bubble_id = 1. Stays until reset.
  - halt_f = 0 in RUN and DRAIN.
- Counters:
  - stall_cnt increments on each RUN hazard cycle.
  - flush_cnt increments on each taken flush.
  - Both saturate at all-ones.
- Reset (rst = 0, asynchronous, effective immediately, including mid-DRAIN or HALTED):
  - State goes to RUN, busy = 0, drain counter = 0, stall_cnt = 0, flush_cnt = 0.
  - halted = 0, halt_f = 0, stall_if = 0, bubble_id = 0, flush_if = 0 while reset is held.

Test Plan:
1. Load-use stall. Issue LW R2,0(R1), then present ADD R3,R2,R4; wb_we/wb_addr=2 arrives 3 cycles after LW issue.
   -> stall_if = 1 for exactly 3 cycles, ADD issues on the 4th, stall_cnt = 3, busy[2] returns to 0.
2. R0 destination. ADDI R0,R1,5, then ADD R3,R0,R0.
   -> busy stays 0, no stall, stall_cnt = 0.
3. Flush beats hazard. ex_branch_taken = 1 while ins_id = ADD R3,R2,R4 with busy[2] = 1.
   -> flush_if = 1, bubble_id = 1, stall_if = 0, busy[3] stays 0, flush_cnt = 1.
4. HLT sequence. HLT issues at cycle t.
   -> DRAIN during t+1..t+3 with stall_if = 1; halted = 1 and halt_f = 1 from t+4 onward. A WB clear of R7 during DRAIN still clears busy[7].
5. Set beats clear. Issue LW R5 in the same cycle that wb_we = 1 with wb_addr = 5.
   -> busy[5] = 1 next cycle.
6. Async reset mid-drain. Drop rst in DRAIN between clock edges.
   -> immediately state = RUN, busy = 0, counters = 0, all outputs 0. After release, a normal ADD issues without stall.
